// File: rtl/ladowacz_programu.sv
// ladowacz_programu: 8N1 UART program loader that writes 16-bit words into program memory.
// Define LADOWACZ_TIMEOUT_EN to abort a stalled load after 1024 idle bit periods.
module ladowacz_programu #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  blad
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [7:0]  SYNC  = 8'hA5;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_d;
    logic [1:0]       r_state;
    logic [1:0]       r_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             bajt_ok;
    logic             bajt_err;
    logic             tick_half;
    logic             tick_full;

    logic [2:0]       m_state;
    logic [2:0]       m_next;
    logic [7:0]       words;
    logic [7:0]       sum;
    logic             timeout;
    logic             abort;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign tick_half = (bit_cnt == CNT_W'(HALF - 1));
    assign tick_full = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rx_d && !rx_s2) r_next = R_START;
            R_START: if (tick_half) r_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (tick_full && (bit_idx == 3'd7)) r_next = R_STOP;
            R_STOP:  if (tick_full) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Bit timing and shift register; returning to idle mid stop bit lets back-to-back bytes re-arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            bajt_ok  <= 1'b0;
            bajt_err <= 1'b0;
        end else begin
            bajt_ok  <= 1'b0;
            bajt_err <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                end
                R_START: begin
                    bit_cnt <= tick_half ? '0 : bit_cnt + CNT_W'(1);
                end
                R_DATA: begin
                    if (tick_full) begin
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (tick_full) begin
                        bit_cnt  <= '0;
                        bajt_ok  <= rx_s2;
                        bajt_err <= !rx_s2;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

`ifdef LADOWACZ_TIMEOUT_EN
    localparam int unsigned TO_LIMIT = 1024 * CLKS_PER_BIT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 2);

    logic [TO_W-1:0] to_cnt;

    assign timeout = (m_state != S_IDLE) && (to_cnt > TO_W'(TO_LIMIT));

    // Cycles since the last accepted byte; saturates once the timeout fires.
    always_ff @(posedge clk) begin
        if (rst || (m_state == S_IDLE) || bajt_ok) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign abort = (m_state != S_IDLE) && (bajt_err || timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_state <= S_IDLE;
        end else begin
            m_state <= m_next;
        end
    end

    always_comb begin
        m_next = m_state;
        if (abort) begin
            m_next = S_IDLE;
        end else if (bajt_ok) begin
            case (m_state)
                S_IDLE:  if (rx_byte == SYNC) m_next = S_COUNT;
                S_COUNT: m_next = S_HI;
                S_HI:    m_next = S_LO;
                S_LO:    m_next = (words == 8'd1) ? S_CHK : S_HI;
                S_CHK:   m_next = S_IDLE;
                default: m_next = S_IDLE;
            endcase
        end
    end

    // Frame datapath and registered outputs; a word count of 0 wraps to 256 via the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            blad      <= 1'b0;
            words     <= '0;
            sum       <= '0;
        end else begin
            prog_we <= 1'b0;
            done    <= 1'b0;
            if (prog_we) begin
                prog_addr <= prog_addr + ADDR_WIDTH'(1);
            end
            if (abort) begin
                blad <= 1'b1;
                busy <= 1'b0;
            end else if (bajt_ok) begin
                case (m_state)
                    S_IDLE: begin
                        if (rx_byte == SYNC) begin
                            cpu_hold  <= 1'b1;
                            busy      <= 1'b1;
                            blad      <= 1'b0;
                            prog_addr <= '0;
                            sum       <= '0;
                        end
                    end
                    S_COUNT: begin
                        words <= rx_byte;
                        sum   <= sum + rx_byte;
                    end
                    S_HI: begin
                        prog_data[DATA_WIDTH-1 -: 8] <= rx_byte;
                        sum                          <= sum + rx_byte;
                    end
                    S_LO: begin
                        prog_data[7:0] <= rx_byte;
                        sum            <= sum + rx_byte;
                        words          <= words - 8'd1;
                        prog_we        <= 1'b1;
                    end
                    S_CHK: begin
                        busy <= 1'b0;
                        if (rx_byte == sum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            blad <= 1'b1;
                        end
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
